// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control/status bundle for countdown_timer.
//   load_i  : load value_i into the count and abort any run
//   value_i : preset value (WIDTH bits)
//   start_i : begin counting from IDLE
//   pause_i : level, hold count and prescaler while high
//   out_o   : current count
//   busy_o  : high while running or paused
//   zero_o  : out_o == 0
//   done_o  : 1-cycle pulse when the count reaches 0
// master drives the controls, slave (the timer) drives the status.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_i;
  logic [WIDTH-1:0] value_i;
  logic             start_i;
  logic             pause_i;
  logic [WIDTH-1:0] out_o;
  logic             busy_o;
  logic             zero_o;
  logic             done_o;

  modport master (
    output load_i, value_i, start_i, pause_i,
    input  out_o, busy_o, zero_o, done_o
  );

  modport slave (
    input  load_i, value_i, start_i, pause_i,
    output out_o, busy_o, zero_o, done_o
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter decremented once every PRESCALE
// clocks while running; pulses done_o for one cycle when the count hits 0.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-high reset
//   bus     : countdown_timer_if.slave (load/value/start/pause in,
//             out/busy/zero/done out)
// Parameters: WIDTH (count width), PRESCALE (clocks per decrement, >=1).
// Build option: COUNTDOWN_AUTORELOAD_EN -- when defined, a reload register
// captures value_i on load and a run that reaches 0 restarts from it
// (unless it is 0), giving a periodic done_o.
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  countdown_timer_if.slave bus
);
  localparam int PSW = $clog2(PRESCALE) + 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [PSW-1:0]   pre, pre_nxt;
  logic             done, done_nxt;
  logic             tick;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)          reload <= '0;
    else if (bus.load_i)  reload <= bus.value_i;
  end
`endif

  // Last prescaler cycle of a decrement period.
  assign tick = (pre == PSW'(PRESCALE - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      count <= '0;
      pre   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      pre   <= pre_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pre_nxt   = pre;
    done_nxt  = 1'b0;
    if (bus.load_i) begin
      count_nxt = bus.value_i;
      pre_nxt   = '0;
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // A start with nothing to count is ignored.
          if (bus.start_i && count != '0) begin
            state_nxt = RUN;
            pre_nxt   = '0;
          end
        end
        RUN: begin
          if (bus.pause_i) begin
            state_nxt = PAUSE;
          end else if (tick) begin
            pre_nxt   = '0;
            count_nxt = count - WIDTH'(1);
            if (count == WIDTH'(1)) begin
              done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (reload != '0) count_nxt = reload;
              else              state_nxt = IDLE;
`else
              state_nxt = IDLE;
`endif
            end
          end else begin
            pre_nxt = pre + PSW'(1);
          end
        end
        PAUSE: begin
          // Resume edge only changes state; prescaler continues from its held value.
          if (!bus.pause_i) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.out_o  = count;
  assign bus.busy_o = (state != IDLE);
  assign bus.zero_o = (count == '0);
  assign bus.done_o = done;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: two timers (PRESCALE 1 and 3) driven with identical
// stimulus, checked every cycle against an elapsed-time reference model,
// plus directed scenarios for reset, latency, pause, load and start corners.
module tb_countdown_timer;
  localparam int W  = 4;
  localparam int PA = 1;
  localparam int PB = 3;
`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [W-1:0] value = '0;

  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(W)) ia ();
  countdown_timer_if #(.WIDTH(W)) ib ();

  assign ia.load_i  = load;
  assign ia.value_i = value;
  assign ia.start_i = start;
  assign ia.pause_i = pause;
  assign ib.load_i  = load;
  assign ib.value_i = value;
  assign ib.start_i = start;
  assign ib.pause_i = pause;

  countdown_timer #(.WIDTH(W), .PRESCALE(PA)) dut_a (.clk_i(clk), .reset_i(rst), .bus(ia));
  countdown_timer #(.WIDTH(W), .PRESCALE(PB)) dut_b (.clk_i(clk), .reset_i(rst), .bus(ib));

  // Reference: mode 0 idle, 1 running, 2 paused. While running the count is
  // base - (active cycles / P); the run ends after base*P active cycles.
  typedef struct {
    int mode;
    int cnt;
    int base;
    int t;
    int rel;
    bit done;
  } mdl_t;

  mdl_t ma, mb;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = 0; m.cnt = 0; m.base = 0; m.t = 0; m.rel = 0; m.done = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t mi, int p, bit ld, int val, bit st, bit ps);
    mdl_t m;
    m = mi;
    m.done = 1'b0;
    if (ld) begin
      m.cnt = val; m.rel = val; m.mode = 0; m.t = 0;
    end else if (m.mode == 0) begin
      if (st && m.cnt != 0) begin
        m.mode = 1; m.base = m.cnt; m.t = 0;
      end
    end else if (m.mode == 1) begin
      if (ps) m.mode = 2;
      else begin
        m.t = m.t + 1;
        m.cnt = m.base - m.t / p;
        if (m.t == m.base * p) begin
          m.done = 1'b1;
          if (AUTO && m.rel != 0) begin
            m.base = m.rel; m.t = 0; m.cnt = m.rel;
          end else m.mode = 0;
        end
      end
    end else begin
      if (!ps) m.mode = 1;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cmp_all();
    chk("a.out",  32'(ia.out_o),  32'(ma.cnt));
    chk("a.busy", 32'(ia.busy_o), 32'(ma.mode != 0));
    chk("a.zero", 32'(ia.zero_o), 32'(ma.cnt == 0));
    chk("a.done", 32'(ia.done_o), 32'(ma.done));
    chk("b.out",  32'(ib.out_o),  32'(mb.cnt));
    chk("b.busy", 32'(ib.busy_o), 32'(mb.mode != 0));
    chk("b.zero", 32'(ib.zero_o), 32'(mb.cnt == 0));
    chk("b.done", 32'(ib.done_o), 32'(mb.done));
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs are
  // compared at the following falling edge, where new inputs may be set.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      ma = mreset(); mb = mreset();
    end else begin
      ma = mstep(ma, PA, load, int'(value), start, pause);
      mb = mstep(mb, PB, load, int'(value), start, pause);
    end
    cyc++;
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    int nb, nd, dout, rise, dcyc, anyb;
    ma = mreset(); mb = mreset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_all();

    // PRESCALE=1: load 5, start; busy/done shape on dut_a.
    value = 4'd5; load = 1'b1; step(); load = 1'b0;
    nb = 0; nd = 0; dout = -1;
    for (int i = 0; i < 8; i++) begin
      start = (i == 0);
      step();
      start = 1'b0;
      if (ia.busy_o) nb++;
      if (ia.done_o) begin nd++; dout = int'(ia.out_o); end
    end
    chk("t2.busy_cycles", 32'(nb), AUTO ? 32'd8 : 32'd5);
    chk("t2.done_cycles", 32'(nd), 32'd1);
    chk("t2.done_out", 32'(dout), AUTO ? 32'd5 : 32'd0);

    // PRESCALE=3: load 2, start, pause after first decrement. Pause high for
    // three sampled edges freezes four counting edges (entry and resume edges hold).
    value = 4'd2; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    rise = cyc; dcyc = -1;
    repeat (3) step();
    chk("t3.first_dec", 32'(ib.out_o), 32'd1);
    pause = 1'b1;
    repeat (3) begin
      step();
      chk("t3.frozen", 32'(ib.out_o), 32'd1);
    end
    pause = 1'b0;
    for (int i = 0; i < 30 && dcyc < 0; i++) begin
      step();
      if (ib.done_o) dcyc = cyc;
    end
    chk("t3.latency", 32'(dcyc - rise), 32'd10);

    // Load 0 then start: nothing happens.
    value = 4'd0; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    anyb = int'(ia.busy_o | ib.busy_o | ia.done_o | ib.done_o);
    repeat (3) begin
      step();
      anyb |= int'(ia.busy_o | ib.busy_o | ia.done_o | ib.done_o);
    end
    chk("t4.zero_start", 32'(anyb), 32'd0);

    // Load 7, start, reload 3 mid-run.
    value = 4'd7; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (2) step();
    value = 4'd3; load = 1'b1; step(); load = 1'b0;
    chk("t4.abort_out", 32'(ia.out_o), 32'd3);
    chk("t4.abort_busy", 32'(ia.busy_o | ib.busy_o), 32'd0);
    chk("t4.abort_done", 32'(ia.done_o | ib.done_o), 32'd0);

    // Same-edge load and start: load wins; next start runs.
    value = 4'd4; load = 1'b1; start = 1'b1; step(); load = 1'b0;
    chk("t5.load_wins_busy", 32'(ib.busy_o), 32'd0);
    chk("t5.load_wins_out", 32'(ib.out_o), 32'd4);
    step(); start = 1'b0;
    chk("t5.next_start", 32'(ib.busy_o), 32'd1);
    step();

    // Asynchronous reset between edges, mid-run.
    #2 rst = 1'b1;
    #1;
    chk("t1.rst_out",  32'(ib.out_o),  32'd0);
    chk("t1.rst_zero", 32'(ib.zero_o), 32'd1);
    chk("t1.rst_busy", 32'(ib.busy_o), 32'd0);
    chk("t1.rst_done", 32'(ia.done_o | ib.done_o), 32'd0);
    ma = mreset(); mb = mreset();
    step();
    rst = 1'b0;

`ifdef COUNTDOWN_AUTORELOAD_EN
    // Autoreload: done every 3 cycles, load stops the run.
    value = 4'd3; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    nd = 0;
    repeat (9) begin
      step();
      if (ia.done_o) nd++;
    end
    chk("t6.reload_dones", 32'(nd), 32'd3);
    chk("t6.still_busy", 32'(ia.busy_o), 32'd1);
    load = 1'b1; step(); load = 1'b0;
    chk("t6.load_stops", 32'(ia.busy_o), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom % 24) == 0;
      value = W'($urandom);
      start = ($urandom % 4) == 0;
      pause = ($urandom % 5) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
